// File: rtl/fp_adder_param.sv
// fp_adder_param: pipelined IEEE-754-style adder/subtractor with flush-to-zero.
// Three arithmetic stages are followed by a plain delay line, so the total
// latency is LATENCY cycles at one operation per clock.
module fp_adder_param #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 11,
    parameter int USER_W  = 1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_axis_a_tvalid,
    input  logic [EXP_W+MAN_W:0]       s_axis_a_tdata,
    input  logic                       s_axis_b_tvalid,
    input  logic [EXP_W+MAN_W:0]       s_axis_b_tdata,
    input  logic                       s_axis_op,
    input  logic [USER_W-1:0]          s_axis_tuser,
    output logic                       m_axis_result_tvalid,
    output logic [EXP_W+MAN_W:0]       m_axis_result_tdata,
    output logic [USER_W-1:0]          m_axis_result_tuser
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int XW   = MAN_W + 4;              // implicit + frac + guard/round/sticky
    localparam int SW   = MAN_W + 5;              // XW plus carry-out
    localparam int DLY  = LATENCY - 3;            // stages after the arithmetic core
    localparam int LZW  = $clog2(SW + 1);
    localparam int EW2  = EXP_W + LZW + 1;        // offset exponent, never negative
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, specials, swap, align
    // ------------------------------------------------------------------
    logic              w_acc;
    logic              w_sa, w_sb;
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [MAN_W-1:0]  w_fa, w_fb;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [W-2:0]      w_a_key, w_b_key;
    logic              w_swap;
    logic              w_sx, w_sy;
    logic [EXP_W-1:0]  w_ex, w_ey, w_d;
    logic [MAN_W:0]    w_ma, w_mb, w_mx, w_my;
    logic [XW-1:0]     w_yext, w_yal;
    logic [2*XW-1:0]   w_ysh;
    logic              w_spc;
    logic [W-1:0]      w_spc_data;

    assign w_acc    = s_axis_a_tvalid & s_axis_b_tvalid;
    assign w_sa     = s_axis_a_tdata[W-1];
    assign w_ea     = s_axis_a_tdata[W-2 -: EXP_W];
    assign w_fa     = s_axis_a_tdata[MAN_W-1:0];
    // subtraction is just B with its sign flipped, specials included
    assign w_sb     = s_axis_b_tdata[W-1] ^ s_axis_op;
    assign w_eb     = s_axis_b_tdata[W-2 -: EXP_W];
    assign w_fb     = s_axis_b_tdata[MAN_W-1:0];

    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);

    // denormals flush to zero: no implicit bit, magnitude key zero
    assign w_ma     = w_a_zero ? '0 : {1'b1, w_fa};
    assign w_mb     = w_b_zero ? '0 : {1'b1, w_fb};
    assign w_a_key  = w_a_zero ? '0 : {w_ea, w_fa};
    assign w_b_key  = w_b_zero ? '0 : {w_eb, w_fb};
    assign w_swap   = (w_b_key > w_a_key);

    assign w_sx     = w_swap ? w_sb : w_sa;
    assign w_sy     = w_swap ? w_sa : w_sb;
    assign w_ex     = w_swap ? w_eb : w_ea;
    assign w_ey     = w_swap ? w_ea : w_eb;
    assign w_mx     = w_swap ? w_mb : w_ma;
    assign w_my     = w_swap ? w_ma : w_mb;
    assign w_d      = w_ex - w_ey;

    // special-case result, highest priority first
    always_comb begin
        w_spc      = 1'b1;
        w_spc_data = QNAN;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
            w_spc_data = QNAN;
        else if (w_a_inf)
            w_spc_data = {w_sa, EXP_ONES, {MAN_W{1'b0}}};
        else if (w_b_inf)
            w_spc_data = {w_sb, EXP_ONES, {MAN_W{1'b0}}};
        else
            w_spc = 1'b0;
    end

    // align smaller operand; bits shifted past the guard/round collapse into sticky
    always_comb begin
        w_yext = {w_my, 3'b000};
        w_ysh  = {w_yext, {XW{1'b0}}} >> w_d;
        if (32'(w_d) >= 32'(MAN_W + 3))
            w_yal = {{(XW-1){1'b0}}, |w_my};
        else
            w_yal = w_ysh[2*XW-1:XW] | {{(XW-1){1'b0}}, |w_ysh[XW-1:0]};
    end

    logic [LATENCY-1:0] r_vld_pipe;
    logic               r1_sx, r1_sub, r1_zs, r1_spc;
    logic [EXP_W-1:0]   r1_ex;
    logic [MAN_W:0]     r1_mx;
    logic [XW-1:0]      r1_my;
    logic [W-1:0]       r1_spc_data;
    logic [USER_W-1:0]  r1_user;

    // stage 1 register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r1_sx <= 1'b0; r1_sub <= 1'b0; r1_zs <= 1'b0; r1_spc <= 1'b0;
            r1_ex <= '0; r1_mx <= '0; r1_my <= '0; r1_spc_data <= '0; r1_user <= '0;
        end else begin
            r1_sx       <= w_sx;
            r1_sub      <= w_sx ^ w_sy;
            r1_zs       <= w_sx & w_sy;     // sign of a zero sum: -0 only for -0 + -0
            r1_spc      <= w_spc;
            r1_ex       <= w_ex;
            r1_mx       <= w_mx;
            r1_my       <= w_yal;
            r1_spc_data <= w_spc_data;
            r1_user     <= s_axis_tuser;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude add / subtract (|X| >= |Y| so no negative result)
    // ------------------------------------------------------------------
    logic [SW-1:0] w_xop, w_yop, w_sum;
    assign w_xop = {1'b0, r1_mx, 3'b000};
    assign w_yop = {1'b0, r1_my};
    assign w_sum = r1_sub ? (w_xop - w_yop) : (w_xop + w_yop);

    logic               r2_sx, r2_zs, r2_spc;
    logic [EXP_W-1:0]   r2_ex;
    logic [SW-1:0]      r2_sum;
    logic [W-1:0]       r2_spc_data;
    logic [USER_W-1:0]  r2_user;

    // stage 2 register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r2_sx <= 1'b0; r2_zs <= 1'b0; r2_spc <= 1'b0;
            r2_ex <= '0; r2_sum <= '0; r2_spc_data <= '0; r2_user <= '0;
        end else begin
            r2_sx       <= r1_sx;
            r2_zs       <= r1_zs;
            r2_spc      <= r1_spc;
            r2_ex       <= r1_ex;
            r2_sum      <= w_sum;
            r2_spc_data <= r1_spc_data;
            r2_user     <= r1_user;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: leading-zero count, normalize, round-to-nearest-even, pack
    // ------------------------------------------------------------------
    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) n = LZW'(SW - 1 - i);
        return n;
    endfunction

    logic [LZW-1:0]   w_lz;
    logic [SW-1:0]    w_norm;
    logic [MAN_W:0]   w_man;
    logic             w_g, w_st, w_inc;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_frac;
    logic [EW2-1:0]   w_eoff, w_ef;
    logic [W-1:0]     w_res;

    // exponent is kept offset by SW so underflow stays a plain unsigned compare
    always_comb begin
        w_lz   = lzc(r2_sum);
        w_norm = r2_sum << w_lz;
        w_man  = w_norm[SW-1 -: MAN_W+1];
        w_g    = w_norm[3];
        w_st   = |w_norm[2:0];
        w_inc  = w_g & (w_st | w_man[0]);
        w_rnd  = {1'b0, w_man} + (MAN_W+2)'(w_inc);
        w_frac = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
        w_eoff = EW2'(r2_ex) + EW2'(SW + 1) + EW2'(w_rnd[MAN_W+1]) - EW2'(w_lz);
        w_ef   = w_eoff - EW2'(SW);
        if (r2_spc)
            w_res = r2_spc_data;
        else if (r2_sum == '0)
            w_res = {r2_zs, {(W-1){1'b0}}};
        else if (w_eoff <= EW2'(SW))
            w_res = {r2_sx, {(W-1){1'b0}}};
        else if (w_ef >= EW2'(EMAX))
            w_res = {r2_sx, EXP_ONES, {MAN_W{1'b0}}};
        else
            w_res = {r2_sx, w_ef[EXP_W-1:0], w_frac};
    end

    // ------------------------------------------------------------------
    // Stage 3 register plus delay line; index 0 is the core output
    // ------------------------------------------------------------------
    logic [W-1:0]      r_dat [0:DLY];
    logic [USER_W-1:0] r_usr [0:DLY];

    // valid shift register, bit j is the valid of stage j+1
    always_ff @(posedge aclk) begin
        if (!aresetn) r_vld_pipe <= '0;
        else          r_vld_pipe <= {r_vld_pipe[LATENCY-2:0], w_acc};
    end

    // result / tag delay line
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i <= DLY; i++) begin
                r_dat[i] <= '0;
                r_usr[i] <= '0;
            end
        end else begin
            r_dat[0] <= w_res;
            r_usr[0] <= r2_user;
            for (int i = 1; i <= DLY; i++) begin
                r_dat[i] <= r_dat[i-1];
                r_usr[i] <= r_usr[i-1];
            end
        end
    end

    assign m_axis_result_tvalid = r_vld_pipe[LATENCY-1];
    assign m_axis_result_tdata  = r_dat[DLY];
    assign m_axis_result_tuser  = r_usr[DLY];
endmodule

// File: tb/tb_fp_adder_param.sv
// tb_fp_adder_param: random and directed checks of fp_adder_param in single
// and half precision against an exact-integer rounding model.
module tb_fp_adder_param;
    localparam int SP_LAT = 11;
    localparam int HP_LAT = 4;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn;
    logic        sa_v, sb_v, s_op;
    logic [31:0] s_a, s_b;
    logic [7:0]  s_u;
    logic        so_v;
    logic [31:0] so_d;
    logic [7:0]  so_u;
    logic        ha_v, hb_v, h_op;
    logic [15:0] h_a, h_b;
    logic [0:0]  h_u;
    logic        ho_v;
    logic [15:0] ho_d;
    logic [0:0]  ho_u;

    fp_adder_param #(.EXP_W(8), .MAN_W(23), .LATENCY(SP_LAT), .USER_W(8)) u_sp (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_a_tvalid(sa_v), .s_axis_a_tdata(s_a),
        .s_axis_b_tvalid(sb_v), .s_axis_b_tdata(s_b),
        .s_axis_op(s_op), .s_axis_tuser(s_u),
        .m_axis_result_tvalid(so_v), .m_axis_result_tdata(so_d), .m_axis_result_tuser(so_u)
    );

    fp_adder_param #(.EXP_W(5), .MAN_W(10), .LATENCY(HP_LAT), .USER_W(1)) u_hp (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_a_tvalid(ha_v), .s_axis_a_tdata(h_a),
        .s_axis_b_tvalid(hb_v), .s_axis_b_tdata(h_b),
        .s_axis_op(h_op), .s_axis_tuser(h_u),
        .m_axis_result_tvalid(ho_v), .m_axis_result_tdata(ho_d), .m_axis_result_tuser(ho_u)
    );

    typedef struct {
        logic [31:0] d;
        logic [7:0]  u;
        int          due;
    } exp_t;

    exp_t q_sp[$];
    exp_t q_hp[$];
    exp_t m_sp, m_hp;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, want, cyc);
        end
    endtask

    function automatic logic [31:0] pk(input logic sg, input int e, input logic [31:0] f,
                                       input int ew, input int mw);
        return (32'(sg) << (ew + mw)) | (32'(e) << mw) | f;
    endfunction

    // exact sum on an integer grid of the smallest normal ulp, then RNE
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic op, input int ew, input int mw);
        logic [319:0] ia, ib, s, q, rem, half;
        logic         sa, sb, sr;
        int           emax, ea, eb, p, k, be;
        logic [31:0]  fa, fb, fmask;
        emax  = (1 << ew) - 1;
        fmask = (32'd1 << mw) - 32'd1;
        sa = a[ew+mw];
        sb = b[ew+mw] ^ op;
        ea = int'((a >> mw) & 32'(emax));
        eb = int'((b >> mw) & 32'(emax));
        fa = a & fmask;
        fb = b & fmask;
        if ((ea == emax && fa != 0) || (eb == emax && fb != 0) ||
            (ea == emax && eb == emax && sa != sb))
            return pk(1'b0, emax, 32'd1 << (mw - 1), ew, mw);
        if (ea == emax) return pk(sa, emax, 32'd0, ew, mw);
        if (eb == emax) return pk(sb, emax, 32'd0, ew, mw);
        ia = (ea == 0) ? '0 : (320'(fa) | (320'd1 << mw)) << (ea - 1);
        ib = (eb == 0) ? '0 : (320'(fb) | (320'd1 << mw)) << (eb - 1);
        if (sa == sb)      begin s = ia + ib; sr = sa; end
        else if (ia >= ib) begin s = ia - ib; sr = sa; end
        else               begin s = ib - ia; sr = sb; end
        if (s == 0) return pk(sa & sb, 0, 32'd0, ew, mw);
        p = 0;
        for (int i = 0; i < 320; i++) if (s[i]) p = i;
        be = p - mw + 1;
        if (p > mw) begin
            k    = p - mw;
            q    = s >> k;
            rem  = s & ((320'd1 << k) - 320'd1);
            half = 320'd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 320'd1;
            if (q[mw+1]) begin q = q >> 1; be++; end
        end else begin
            q = s << (mw - p);
        end
        if (be >= emax) return pk(sr, emax, 32'd0, ew, mw);
        if (be <= 0)    return pk(sr, 0, 32'd0, ew, mw);
        return pk(sr, be, q[31:0] & fmask, ew, mw);
    endfunction

    // scoreboards: every valid must match the oldest expected op, on its due cycle
    always @(negedge aclk) begin
        if (so_v) begin
            if (q_sp.size() == 0) chk("sp_spurious_vld", 64'(so_v), 64'd0);
            else begin
                m_sp = q_sp.pop_front();
                chk("sp_data", 64'(so_d), 64'(m_sp.d));
                chk("sp_user", 64'(so_u), 64'(m_sp.u));
                chk("sp_latency", 64'(cyc), 64'(m_sp.due));
            end
        end else if (q_sp.size() > 0 && q_sp[0].due <= cyc) begin
            chk("sp_missing_vld", 64'(so_v), 64'd1);
            void'(q_sp.pop_front());
        end
    end

    always @(negedge aclk) begin
        if (ho_v) begin
            if (q_hp.size() == 0) chk("hp_spurious_vld", 64'(ho_v), 64'd0);
            else begin
                m_hp = q_hp.pop_front();
                chk("hp_data", 64'(ho_d), 64'(m_hp.d));
                chk("hp_user", 64'(ho_u), 64'(m_hp.u));
                chk("hp_latency", 64'(cyc), 64'(m_hp.due));
            end
        end else if (q_hp.size() > 0 && q_hp[0].due <= cyc) begin
            chk("hp_missing_vld", 64'(ho_v), 64'd1);
            void'(q_hp.pop_front());
        end
    end

    task automatic drive_now(input bit hp, input bit va, input bit vb, input logic [31:0] a,
                             input logic [31:0] b, input logic op, input logic [7:0] u,
                             input logic [31:0] want);
        sa_v = 1'b0; sb_v = 1'b0; ha_v = 1'b0; hb_v = 1'b0;
        if (hp) begin
            ha_v = va; hb_v = vb; h_a = a[15:0]; h_b = b[15:0]; h_op = op; h_u = u[0:0];
            if (va && vb && aresetn) q_hp.push_back('{d: want, u: u & 8'h01, due: cyc + HP_LAT});
        end else begin
            sa_v = va; sb_v = vb; s_a = a; s_b = b; s_op = op; s_u = u;
            if (va && vb && aresetn) q_sp.push_back('{d: want, u: u, due: cyc + SP_LAT});
        end
    endtask

    task automatic drive(input bit hp, input bit va, input bit vb, input logic [31:0] a,
                         input logic [31:0] b, input logic op, input logic [7:0] u,
                         input logic [31:0] want);
        @(negedge aclk);
        drive_now(hp, va, vb, a, b, op, u, want);
    endtask

    task automatic chk_zero_out(input string tag);
        chk({tag, "_sp_vld"},  64'(so_v), 64'd0);
        chk({tag, "_sp_data"}, 64'(so_d), 64'd0);
        chk({tag, "_sp_user"}, 64'(so_u), 64'd0);
        chk({tag, "_hp_vld"},  64'(ho_v), 64'd0);
        chk({tag, "_hp_data"}, 64'(ho_d), 64'd0);
        chk({tag, "_hp_user"}, 64'(ho_u), 64'd0);
    endtask

    logic [31:0] SPC [7] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000000,
                             32'h80000000, 32'h00400000, 32'h7F7FFFFF};
    logic [31:0] D_A [9] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h00000001, 32'h80000000};
    logic [31:0] D_B [9] = '{32'h40000000, 32'h40000000, 32'h33800000, 32'h33800001,
                             32'h3F800000, 32'hFF800000, 32'h7F7FFFFF, 32'h00000000, 32'h80000000};
    logic        D_OP [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] D_R [9] = '{32'h40400000, 32'hBF800000, 32'h3F800000, 32'h3F800001,
                             32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};

    function automatic logic [31:0] rnd_a();
        if ($urandom_range(0, 7) == 0) return SPC[$urandom_range(0, 6)];
        return $urandom;
    endfunction

    function automatic logic [31:0] rnd_b(input logic [31:0] a);
        logic [31:0] b;
        b = $urandom;
        case ($urandom_range(0, 5))
            1, 2:    b[30:23] = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
            3:       b = a ^ 32'h80000000 ^ 32'($urandom_range(0, 3));
            4:       b = SPC[$urandom_range(0, 6)];
            default: ;
        endcase
        return b;
    endfunction

    initial begin
        logic [31:0] a, b, r;
        logic        op, va, vb;
        aresetn = 1'b0;
        drive_now(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);
        drive_now(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);
        repeat (3) @(negedge aclk);
        chk_zero_out("reset");
        aresetn = 1'b1;

        // directed single-precision cases; model is also held to the same constants
        for (int i = 0; i < 9; i++) begin
            chk("model_dir", 64'(ref_add(D_A[i], D_B[i], D_OP[i], 8, 23)), 64'(D_R[i]));
            drive(1'b0, 1'b1, 1'b1, D_A[i], D_B[i], D_OP[i], 8'd1, D_R[i]);
        end

        // 64 back-to-back random ops, tag = index
        for (int i = 0; i < 64; i++) begin
            a = rnd_a(); b = rnd_b(a); op = 1'($urandom_range(0, 1));
            drive(1'b0, 1'b1, 1'b1, a, b, op, 8'(i), ref_add(a, b, op, 8, 23));
        end

        // single-sided and idle cycles: only dual-valid cycles produce results
        for (int i = 0; i < 40; i++) begin
            a = rnd_a(); b = rnd_b(a); op = 1'($urandom_range(0, 1));
            va = 1'($urandom_range(0, 1)); vb = 1'($urandom_range(0, 1));
            drive(1'b0, va, vb, a, b, op, 8'(64 + i), ref_add(a, b, op, 8, 23));
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);
        repeat (SP_LAT + 2) @(negedge aclk);

        // reset mid-flight: five ops dropped, the op on release survives
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = rnd_b(a);
            drive(1'b0, 1'b1, 1'b1, a, b, 1'b0, 8'(200 + i), ref_add(a, b, 1'b0, 8, 23));
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);
        @(negedge aclk);
        aresetn = 1'b0;
        drive_now(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);
        q_sp.delete();
        q_hp.delete();
        @(negedge aclk);
        chk_zero_out("midrst");
        aresetn = 1'b1;
        drive_now(1'b0, 1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, 8'd77, 32'h40400000);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);
        repeat (SP_LAT + 2) @(negedge aclk);

        // half precision instance
        chk("model_hp_add", 64'(ref_add(32'h3C00, 32'h4000, 1'b0, 5, 10)), 64'h4200);
        drive(1'b1, 1'b1, 1'b1, 32'h3C00, 32'h4000, 1'b0, 8'd1, 32'h4200);
        drive(1'b1, 1'b1, 1'b1, 32'h7BFF, 32'h7BFF, 1'b0, 8'd0, 32'h7C00);
        for (int i = 0; i < 24; i++) begin
            a = 32'($urandom_range(0, 65535));
            b = ($urandom_range(0, 1) == 1) ? (a ^ 32'h8000 ^ 32'($urandom_range(0, 3)))
                                            : 32'($urandom_range(0, 65535));
            op = 1'($urandom_range(0, 1));
            va = ($urandom_range(0, 3) != 0); vb = ($urandom_range(0, 3) != 0);
            drive(1'b1, va, vb, a, b, op, 8'(i), ref_add(a, b, op, 5, 10));
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0);

        // drain with a bounded wait
        for (int i = 0; i < 40 && (q_sp.size() + q_hp.size()) != 0; i++) @(negedge aclk);
        chk("drain_pending", 64'(q_sp.size() + q_hp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
